// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder: drains every set bit of an accepted request vector,
// one grant per handshake, in fixed-priority or persistent round-robin order.
module prio_encoder_rr #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             rr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic             out_last
);

    if (N < 2 || N > 64 || (2 ** IDX_W) < N) begin : g_param_check
        $fatal(1, "prio_encoder_rr: N must be 2..64 and 2**IDX_W >= N");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [N-1:0] One = N'(1);

    state_e state_q, state_d;

    logic [N-1:0]     pending_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic             mode_q;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [N-1:0]     out_onehot_q;
    logic             out_last_q;

    logic             accept;
    logic             advance;
    logic             load;
    logic             drain_done;
    logic [N-1:0]     src_vec;
    logic             src_mode;
    logic [IDX_W-1:0] eff_ptr;
    logic [N-1:0]     below_mask;
    logic [N-1:0]     below_vec;
    logic [IDX_W-1:0] sel_idx;
    logic [N-1:0]     sel_onehot;
    logic             sel_single;

    function automatic logic [IDX_W-1:0] highest_set(input logic [N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int s = 0; s < N; s++) begin
            if (v[s]) idx = IDX_W'(s);
        end
        return idx;
    endfunction

    assign accept     = (state_q == StIdle) && req_valid && (req != '0);
    assign advance    = (state_q == StBusy) && out_ready;
    assign load       = accept || (advance && (pending_q != '0));
    assign drain_done = advance && (pending_q == '0);

    assign src_vec  = (state_q == StIdle) ? req : pending_q;
    assign src_mode = (state_q == StIdle) ? rr_en : mode_q;
    assign eff_ptr  = src_mode ? rr_ptr_q : '0;

    // Search order is ptr-1 down to 0, then N-1 down to ptr: first look below the
    // pointer, otherwise the highest bit overall must lie at or above it.
    always_comb begin
        below_mask = '0;
        for (int s = 0; s < N; s++) begin
            below_mask[s] = (IDX_W'(s) < eff_ptr);
        end
    end

    assign below_vec  = src_vec & below_mask;
    assign sel_idx    = (below_vec != '0) ? highest_set(below_vec) : highest_set(src_vec);
    assign sel_onehot = One << sel_idx;
    assign sel_single = (src_vec & (src_vec - One)) == '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StBusy;
            StBusy: if (drain_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready  = (state_q == StIdle);
        out_valid  = out_valid_q;
        out_idx    = out_idx_q;
        out_onehot = out_onehot_q;
        out_last   = out_last_q;
    end

    // Grant datapath; out_idx/out_onehot keep their last value after a drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            out_last_q   <= 1'b0;
        end else begin
            if (accept) begin
                mode_q <= rr_en;
            end
            if (load) begin
                out_valid_q  <= 1'b1;
                out_idx_q    <= sel_idx;
                out_onehot_q <= sel_onehot;
                out_last_q   <= sel_single;
                pending_q    <= src_vec & ~sel_onehot;
                rr_ptr_q     <= sel_idx;
            end else if (drain_done) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered N-to-log2(N) encoder. It generalises the team's combinational 8x3 encoder to any width.
- Accepts a multi-hot request vector through a valid/ready handshake. Emits the index of every set bit, one per output handshake.
- Selection order is fixed priority (highest index first) or round-robin, with the round-robin pointer kept across vectors.
- Sits between request-gathering logic and a single-grant consumer, for example an arbiter front-end or an interrupt vector generator.

Parameters:
- N, 8, number of request lines (2..64; need not be a power of 2).
- IDX_W, 3, index width; must satisfy 2**IDX_W >= N. Elaboration-time check; a violation is a fatal error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i set means index i is requested.
- req_valid  input  1  req is valid this cycle.
- req_ready  output  1  block can accept a vector.
- rr_en  input  1  0 selects fixed priority, 1 selects round-robin; latched at vector accept.
- out_valid  output  1  out_idx / out_onehot hold a grant.
- out_ready  input  1  consumer accepts the grant.
- out_idx  output  IDX_W  granted index, binary.
- out_onehot  output  N  granted index, one-hot.
- out_last  output  1  current grant is the final set bit of the vector.

Behaviour:
- Reset (asynchronous, immediate on rst_n low, no clock needed):
  - state=IDLE, pending=0, rr_ptr=0, mode=0.
  - out_valid=0, out_idx=0, out_onehot=0, out_last=0.
  - req_ready=1 once rst_n is released.
  - Reset mid-drain discards the pending vector with no further grants.
- States: IDLE and BUSY. req_ready = (state==IDLE), decoded from the registered state.
- IDLE, req_valid=1, req!=0:
  - Accept the vector and latch mode<=rr_en.
  - Select index s from req (rules below).
  - Register out_idx=s and out_onehot=1<<s; set out_valid=1; set out_last=(popcount(req)==1).
  - pending<=req & ~onehot(s); rr_ptr<=s; go to BUSY.
  - Latency: out_valid is high in the cycle after the accept edge.
- IDLE, req_valid=1, req==0: accepted and dropped. No output, stay in IDLE, req_ready stays 1.
- BUSY, out_valid=1, out_ready=0: every register holds. out_idx, out_onehot and out_last are stable, and pending is unchanged.
- BUSY, out_valid=1, out_ready=1:
  - If pending!=0: select s from pending, register the outputs as above (out_last=(popcount(pending)==1)), pending<=pending & ~onehot(s), rr_ptr<=s. Result is one grant per cycle with no bubbles.
  - If pending==0: out_valid<=0, out_last<=0, state<=IDLE. req_ready=1 the next cycle. out_idx and out_onehot keep their last value.
- Selection rules:
  - Fixed priority (mode=0): highest set index wins.
  - Round-robin (mode=1): search descending from index (rr_ptr-1) and wrap from 0 to N-1. The first set bit wins, and rr_ptr's own bit is checked last.
    - With rr_ptr=0 the search starts at N-1, which equals the fixed-priority result.
    - For non-power-of-2 N, the wrap goes to N-1, not to 2**IDX_W-1.
  - rr_ptr updates on every grant in both modes and persists across vectors and mode changes.
- Invariant: every set bit of an accepted vector is granted exactly once; no index >= N is ever produced.
- req is sampled only at the accept edge; changes to req while BUSY have no effect.

Test Plan:
- Reset: with clk stopped, assert rst_n=0 -> out_valid=0, out_idx=0, out_onehot=0; after release, req_ready=1.
- Fixed mode, N=8: req=8'b1010_0101, out_ready=1 held -> out_idx 7,5,2,0 on 4 consecutive cycles; out_last=1 only with idx 0; req_ready=1 on the cycle after the last handshake.
- Backpressure: same vector, out_ready=0 for 3 cycles after the first grant -> out_idx=7 and out_onehot=8'h80 stable; then out_ready=1 -> 5,2,0 follow back-to-back.
- Round-robin persistence:
  - Setup: rr_en=1; vector 8'b0001_0000 -> idx 4 (rr_ptr=4).
  - RR step: vector 8'b1000_1001 -> idx 3,0,7.
  - Fixed comparison: repeat the second vector with rr_en=0 -> idx 7,3,0.
- Zero vector: req_valid=1, req=0 -> out_valid stays 0 and req_ready stays 1. A following vector 8'h01 -> idx 0 with out_last=1.
- Async reset mid-drain: rst_n low between clock edges after the second grant of 8'hFF -> outputs clear immediately. After release, vector 8'h02 -> idx 1 (rr_ptr was reset to 0).
